// File: rtl/krnl_partialknn_local_buf_ctrl.sv
// Local buffer controller: streams words into a single-port URAM (load) or
// streams them back out through a credit-limited output FIFO (drain).
module krnl_partialknn_local_buf_ctrl #(
    parameter int unsigned DataWidth    = 256,
    parameter int unsigned AddressWidth = 11,
    parameter int unsigned ReadLatency  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AddressWidth-1:0] cmd_base,
    input  logic [AddressWidth:0]   cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DataWidth-1:0]    wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DataWidth-1:0]    rd_data,
    output logic                    done,
    output logic [AddressWidth-1:0] mem_address0,
    output logic                    mem_ce0,
    output logic                    mem_we0,
    output logic [DataWidth-1:0]    mem_d0,
    input  logic [DataWidth-1:0]    mem_q0
);
    localparam int unsigned Depth = ReadLatency + 2;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned LenW  = AddressWidth + 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, DONE} state_e;

    state_e                  state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [LenW-1:0]         issue_rem_q, issue_rem_d;
    logic [LenW-1:0]         out_rem_q, out_rem_d;
    logic [ReadLatency-1:0]  vld_q, vld_d;
    logic [CntW-1:0]         inflight_q, inflight_d;
    logic [CntW-1:0]         fcnt_q, fcnt_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [DataWidth-1:0]    fifo_q [Depth];
    logic [DataWidth-1:0]    fifo_d [Depth];

    logic ld_fire;
    logic rd_issue;
    logic push;
    logic pop;
    logic credit_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Reads may only be issued while every outstanding word has a FIFO slot.
    assign credit_ok = ((CntW+1)'(inflight_q) + (CntW+1)'(fcnt_q)) < (CntW+1)'(Depth);
    assign rd_valid  = !reset && (fcnt_q != '0);
    assign rd_data   = fifo_q[rptr_q];

    // Memory port is a combinational view of the current load/drain access.
    assign mem_ce0      = ld_fire | rd_issue;
    assign mem_we0      = ld_fire;
    assign mem_address0 = mem_ce0 ? addr_q : '0;
    assign mem_d0       = ld_fire ? wr_data : '0;

    // Command FSM: next state, handshakes and address/count bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        done        = 1'b0;
        ld_fire     = 1'b0;
        rd_issue    = 1'b0;
        pop         = rd_valid && rd_ready;
        if (pop) begin
            out_rem_d = out_rem_q - LenW'(1);
        end
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        addr_d      = cmd_base;
                        issue_rem_d = cmd_len;
                        out_rem_d   = cmd_len;
                        if (cmd_len == '0) begin
                            state_d = DONE;
                        end else if (cmd_write) begin
                            state_d = LOAD;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                LOAD: begin
                    wr_ready = (issue_rem_q != '0);
                    ld_fire  = wr_valid && wr_ready;
                    if (ld_fire) begin
                        addr_d      = addr_q + AddressWidth'(1);
                        issue_rem_d = issue_rem_q - LenW'(1);
                        if (issue_rem_q == LenW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DRAIN: begin
                    rd_issue = credit_ok && (issue_rem_q != '0);
                    if (rd_issue) begin
                        addr_d      = addr_q + AddressWidth'(1);
                        issue_rem_d = issue_rem_q - LenW'(1);
                        if (issue_rem_q == LenW'(1)) begin
                            state_d = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_rem_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read-return tracking and output FIFO bookkeeping.
    always_comb begin
        push       = vld_q[ReadLatency-1];
        vld_d      = ReadLatency'({vld_q, rd_issue});
        inflight_d = inflight_q + CntW'(rd_issue) - CntW'(push);
        fcnt_d     = fcnt_q + CntW'(push) - CntW'(pop);
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (push) begin
            fifo_d[wptr_q] = mem_q0;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    // Control state; reset abandons the command and forgets in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            out_rem_q   <= '0;
            vld_q       <= '0;
            inflight_q  <= '0;
            fcnt_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            vld_q       <= vld_d;
            inflight_q  <= inflight_d;
            fcnt_q      <= fcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_krnl_partialknn_local_buf_ctrl.sv
// Bench for krnl_partialknn_local_buf_ctrl: URAM model plus a reference image
// of memory contents; each command's expected address/data stream is built
// from (base + i) mod range and compared against the DUT port activity.
module tb_krnl_partialknn_local_buf_ctrl;
    localparam int DW = 256;
    localparam int AW = 11;
    localparam int RL = 2;
    localparam int AR = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0;
    logic          mem_we0;
    logic [DW-1:0] mem_d0;
    logic [DW-1:0] mem_q0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] ref_mem [AR];
    logic [DW-1:0] mem     [AR];
    logic [DW-1:0] qpipe   [RL];

    always #5 clk = ~clk;

    krnl_partialknn_local_buf_ctrl #(
        .DataWidth   (DW),
        .AddressWidth(AW),
        .ReadLatency (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .done        (done),
        .mem_address0(mem_address0),
        .mem_ce0     (mem_ce0),
        .mem_we0     (mem_we0),
        .mem_d0      (mem_d0),
        .mem_q0      (mem_q0)
    );

    // Single-port URAM with ReadLatency-cycle read pipeline; idle slots carry junk.
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) mem[mem_address0] <= mem_d0;
        qpipe[0] <= (mem_ce0 && !mem_we0) ? mem[mem_address0] : {(DW/32){32'hBAD0_BAD0}};
        for (int k = 1; k < RL; k++) qpipe[k] <= qpipe[k-1];
    end
    assign mem_q0 = qpipe[RL-1];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic bit pat(input int e);
        return (e % 4 == 0) || (e % 4 == 3);
    endfunction

    function automatic bit drive_bit(input int mode, input int e);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom % 2) == 1;
        return pat(e);
    endfunction

    // Runs one command; mode 0 = held, 1 = random, 2 = 1,0,0,1 pattern.
    // abort_at >= 0 returns at that cycle with the command still running.
    task automatic do_cmd(input bit wr, input int base, input int len,
                          input int mode, input int abort_at);
        logic [DW-1:0] exp_d[$];
        int exp_a[$];
        int n_ce = 0, n_in = 0, n_out = 0;
        int first_rv = -1, first_hs = -1, last_hs = -1, max_out = 0, occ;
        int e = 0;
        bit seen_done = 1'b0;
        for (int i = 0; i < len; i++) begin
            int a = (base + i) % AR;
            exp_a.push_back(a);
            if (wr) ref_mem[a] = rand_word();
            exp_d.push_back(ref_mem[a]);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        #1;
        chk("cmd_ready_idle", DW'(cmd_ready), DW'(1));
        @(negedge clk);
        while (!seen_done && e < len * 8 + 40) begin
            if (abort_at >= 0 && e == abort_at) return;
            cmd_valid = 1'b0;
            wr_valid  = wr && (n_in < len) && drive_bit(mode, e);
            wr_data   = (wr && n_in < len) ? exp_d[n_in] : '0;
            rd_ready  = !wr && drive_bit(mode, e);
            #1;
            if (mem_we0 && !mem_ce0) chk("we_without_ce", DW'(0), DW'(1));
            if (wr) chk("ce_is_wr_hs", DW'(mem_ce0), DW'(wr_valid && wr_ready));
            if (mem_ce0) begin
                if (n_ce >= len) begin
                    chk("extra_access", DW'(n_ce), DW'(len));
                end else begin
                    chk("mem_addr", DW'(mem_address0), DW'(exp_a[n_ce]));
                    chk("mem_we", DW'(mem_we0), DW'(wr));
                    if (wr) chk("mem_d", mem_d0, exp_d[n_ce]);
                end
                n_ce++;
            end
            if (wr && wr_valid && wr_ready) begin
                if (first_hs < 0) first_hs = e;
                last_hs = e;
                n_in++;
            end
            if (!wr) begin
                occ = n_ce - n_out;
                if (occ > max_out) max_out = occ;
                chk("credit_bound", DW'(occ <= RL + 2), DW'(1));
            end
            if (rd_valid && first_rv < 0) first_rv = e;
            if (rd_valid && rd_ready) begin
                if (n_out < len) chk("rd_data", rd_data, exp_d[n_out]);
                else chk("extra_rd", DW'(n_out), DW'(len));
                last_hs = e;
                n_out++;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cycle", DW'(e), DW'((len == 0) ? 0 : last_hs + 1));
            end
            e++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        if (!seen_done) begin
            chk("timeout", DW'(0), DW'(1));
        end else begin
            chk("done_one_cycle", DW'(done), DW'(0));
            chk("back_to_idle", DW'(cmd_ready), DW'(1));
        end
        chk("access_count", DW'(n_ce), DW'(len));
        if (wr) chk("words_in", DW'(n_in), DW'(len));
        else chk("words_out", DW'(n_out), DW'(len));
        if (!wr && len > 0) chk("first_rd_valid", DW'(first_rv), DW'(RL + 1));
        if (!wr && len >= RL + 2) chk("credit_used", DW'(max_out), DW'(RL + 2));
        if (mode == 0 && len > 0) begin
            if (wr) begin
                chk("load_start", DW'(first_hs), DW'(0));
                chk("load_rate", DW'(last_hs - first_hs), DW'(len - 1));
            end else begin
                chk("drain_rate", DW'(last_hs - first_rv), DW'(len - 1));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, DW'(wr_ready), DW'(0));
        chk({tag, "_rd_valid"}, DW'(rd_valid), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_ce"}, DW'(mem_ce0), DW'(0));
        chk({tag, "_we"}, DW'(mem_we0), DW'(0));
        chk({tag, "_addr"}, DW'(mem_address0), DW'(0));
        chk({tag, "_d"}, mem_d0, '0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;
        #1;
        chk("por_cmd_ready", DW'(cmd_ready), DW'(1));

        // Full-range load then drain: every address exactly once, with wrap.
        do_cmd(1'b1, 'h123, AR, 0, -1);
        do_cmd(1'b0, 'h123, AR, 0, -1);

        do_cmd(1'b1, 'h010, 4, 0, -1);
        do_cmd(1'b0, 'h010, 4, 0, -1);
        do_cmd(1'b0, 'h00C, 8, 2, -1);
        do_cmd(1'b1, 'h7FE, 4, 0, -1);
        do_cmd(1'b0, 'h7FE, 4, 2, -1);
        do_cmd(1'b1, 'h100, 0, 0, -1);
        do_cmd(1'b0, 'h005, 0, 0, -1);

        // Reset in the middle of a drain with reads still in flight.
        do_cmd(1'b0, 'h200, 16, 2, 6);
        reset    = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk_reset_outputs("mid");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("post");
        chk("post_cmd_ready", DW'(cmd_ready), DW'(1));
        for (int i = 0; i < RL + 4; i++) begin
            @(negedge clk);
            #1;
            chk("stale_rd_valid", DW'(rd_valid), DW'(0));
            chk("stale_ce", DW'(mem_ce0), DW'(0));
        end
        rd_ready = 1'b0;
        do_cmd(1'b0, 'h010, 4, 0, -1);

        for (int n = 0; n < 30; n++) begin
            int len;
            len = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 40));
            do_cmd(1'($urandom % 2), int'($urandom % AR), len, int'($urandom % 3), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/krnl_partialknn_local_buf_ctrl.md
KRNL_PARTIALKNN_LOCAL_BUF_CTRL -- requirements
Module: krnl_partialknn_local_buf_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 256, memory word width in bits.
REQ-002 SHALL have parameter AddressWidth, default 11, memory address width; AddressRange = 2**AddressWidth.
REQ-003 SHALL have parameter ReadLatency, default 2, cycles from mem_ce0 (we0=0) to valid mem_q0; legal range 1..4.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when high with cmd_valid.
  cmd_write  in  1  1 = load (stream into memory), 0 = drain (memory to stream).
  cmd_base  in  AddressWidth  first address.
  cmd_len  in  AddressWidth+1  word count, 0..AddressRange.
  wr_valid / wr_ready  in / out  1  load-stream handshake.
  wr_data  in  DataWidth  load word.
  rd_valid / rd_ready  out / in  1  drain-stream handshake.
  rd_data  out  DataWidth  drain word.
  done  out  1  one-cycle pulse at command completion.
  mem_address0  out  AddressWidth  to single-port URAM.
  mem_ce0, mem_we0  out  1  memory enable, write enable.
  mem_d0  out  DataWidth  write data.
  mem_q0  in  DataWidth  read data.

Function
REQ-005 SHALL use states IDLE, LOAD, DRAIN, FLUSH, DONE; cmd_ready high only in IDLE.
REQ-006 IDLE: on cmd_valid, latch base/len/dir; len=0 -> DONE; cmd_write=1 -> LOAD; else -> DRAIN.
REQ-007 LOAD: wr_ready=1 while words remain; each wr_valid&wr_ready drives mem_ce0=1, mem_we0=1, mem_d0=wr_data, mem_address0=current address in that same cycle (combinational pass-through).
REQ-008 LOAD: after last word accepted -> DONE next cycle; wr_ready=0 outside LOAD.
REQ-009 Address i of a command SHALL be (cmd_base + i) mod AddressRange; wrap past AddressRange-1 to 0 is legal.
REQ-010 DRAIN: issue read (mem_ce0=1, mem_we0=0) only when in-flight reads + output FIFO occupancy < ReadLatency+2; FIFO depth ReadLatency+2.
REQ-011 Read data SHALL be captured into output FIFO exactly ReadLatency cycles after issue via a valid shift register; no word dropped or duplicated under any rd_ready pattern.
REQ-012 rd_valid = FIFO non-empty; rd_data = FIFO head; words leave in address order.
REQ-013 DRAIN -> FLUSH when all reads issued; FLUSH -> DONE when in-flight=0, FIFO empty, last word handshaken.
REQ-014 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready may not assert in DONE.
REQ-015 mem_ce0=0 whenever no access is issued; mem_we0=0 whenever mem_ce0=0.
REQ-016 Full-range len=AddressRange SHALL access every address exactly once.
REQ-017 Sustained throughput: one word/cycle in LOAD with wr_valid held, and in DRAIN with rd_ready held, after initial ReadLatency cycles.

Reset
REQ-018 reset SHALL return to IDLE within one clock, abandoning any command, clearing FIFO, counters and in-flight tracking.
REQ-019 Output values during/after reset: cmd_ready=1 (after reset deasserts), wr_ready=0, rd_valid=0, done=0, mem_ce0=0, mem_we0=0, mem_address0=0, mem_d0=0.
REQ-020 Read data returning after reset from pre-reset reads SHALL be discarded.

Verification
REQ-021 Load base=0x010, len=4, wr_valid held, data A0..A3 -> we0 pulses at 0x010..0x013 on 4 consecutive cycles, done 1 cycle after last.
REQ-022 Drain base=0x010, len=4, rd_ready held -> rd_data A0..A3 in order, first rd_valid ReadLatency+1 cycles after command accept, done after 4th handshake.
REQ-023 Drain len=8 with rd_ready toggling 1,0,0,1 pattern -> exactly 8 words in order, FIFO never overflows, issue stalls when credit exhausted.
REQ-024 Load base=0x7FE, len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-025 cmd_len=0 -> no mem_ce0, done pulse 1 cycle after accept; reset asserted mid-drain of len=16 -> outputs at REQ-019 values, no stale rd_valid, next command behaves as fresh.
